// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
//   Shared types and constants for the AES-256 key schedule slice.
//   key256_t : 256-bit cipher key / round_key word, bit 0 = MSB.
//   rk128_t  : 128-bit round key, bit 0 = MSB.
//   AES256_NUM_RK     : number of round keys kept for AES-256 (RK0..RK14).
//   AES256_LAST_ROUND : last round_key round index (r = 1..7).
//   ks_state_e        : sequencer state encoding.
// ----------------------------------------------------------------------------
package aes_pkg;

  typedef logic [0:255] key256_t;
  typedef logic [0:127] rk128_t;

  localparam int AES256_NUM_RK     = 15;
  localparam int AES256_LAST_ROUND = 7;

  typedef enum logic [1:0] {
    KS_IDLE  = 2'd0,
    KS_ISSUE = 2'd1,
    KS_WAIT  = 2'd2,
    KS_DONE  = 2'd3
  } ks_state_e;

endpackage

// File: rtl/rk_buffer.sv
// ----------------------------------------------------------------------------
// rk_buffer
//   Round-key register file: NUM_RK entries of RK_W bits, written a pair at a
//   time (entries 2*wr_pair and 2*wr_pair+1) and read asynchronously.
//   Macro KEY_SCHED_ZEROIZE_EN adds the 'clr' port, which wipes every entry.
//
// Ports:
//   clk      in   clock, posedge
//   clr      in   (KEY_SCHED_ZEROIZE_EN only) clear all entries to 0
//   wr_en    in   write strobe
//   wr_pair  in   pair index; even entry gets wr_data[0:RK_W-1], odd entry
//                 gets wr_data[RK_W:2*RK_W-1] when it exists
//   wr_data  in   two round keys, big-endian
//   rd_idx   in   read index; indices >= NUM_RK read as 0
//   rd_data  out  entry at rd_idx (combinational, old value on same-cycle write)
// ----------------------------------------------------------------------------
module rk_buffer
  import aes_pkg::*;
#(
  parameter int NUM_RK = AES256_NUM_RK,
  parameter int RK_W   = 128
) (
  input  logic                clk,
`ifdef KEY_SCHED_ZEROIZE_EN
  input  logic                clr,
`endif
  input  logic                wr_en,
  input  logic [2:0]          wr_pair,
  input  logic [0:2*RK_W-1]   wr_data,
  input  logic [3:0]          rd_idx,
  output logic [0:RK_W-1]     rd_data
);

  logic [0:RK_W-1] mem [NUM_RK];

  // Pair write. The odd half of the last pair has no entry (RK15 would be
  // index 15), so the loop bound naturally drops it. No reset: contents
  // survive reset unless zeroization is built in.
  always_ff @(posedge clk) begin
`ifdef KEY_SCHED_ZEROIZE_EN
    if (clr) begin
      for (int i = 0; i < NUM_RK; i++) mem[i] <= '0;
    end else
`endif
    if (wr_en) begin
      for (int i = 0; i < NUM_RK; i++) begin
        if ((i / 2) == int'(wr_pair)) begin
          mem[i] <= (i % 2 == 0) ? wr_data[0:RK_W-1] : wr_data[RK_W:2*RK_W-1];
        end
      end
    end
  end

  // Async read as a compare-mux so an out-of-range index yields 0.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RK; i++) begin
      if (rd_idx == 4'(i)) rd_data = mem[i];
    end
  end

endmodule

// File: rtl/key_sched_ctrl.sv
// ----------------------------------------------------------------------------
// key_sched_ctrl
//   AES-256 key expansion sequencer. Takes a 256-bit key from the host, drives
//   the external round_key stage through rounds 1..7, and stores RK0..RK14 in
//   a local buffer the cipher datapath reads by index.
//   Optional macro KEY_SCHED_ZEROIZE_EN: buffer cleared on reset and on every
//   key accept (RK0/RK1 then load one cycle later), and reads return 0 while
//   keys_valid_o is low.
//
// Ports:
//   clk_i, reset_n_i          clock / synchronous active-low reset
//   key_i, key_v_i            cipher key and valid from host
//   key_ready_o               key accepted on key_v_i & key_ready_o
//   rk_k_o, rk_r_o, rk_v_o    request to round_key (k, r, valid)
//   rk_ready_i                round_key ready
//   rk_result_i, rk_v_i       round_key result and valid
//   rk_yumi_o                 consume strobe to round_key
//   rd_idx_i, rd_rk_o         round-key read port
//   keys_valid_o              all 15 round keys valid
//   busy_o                    expansion in progress
// ----------------------------------------------------------------------------
module key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_RK = AES256_NUM_RK,
  parameter int KEY_W  = 256,
  parameter int RK_W   = 128
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [0:KEY_W-1]  key_i,
  input  logic              key_v_i,
  output logic              key_ready_o,
  output logic [0:KEY_W-1]  rk_k_o,
  output logic [3:0]        rk_r_o,
  output logic              rk_v_o,
  input  logic              rk_ready_i,
  input  logic [0:KEY_W-1]  rk_result_i,
  input  logic              rk_v_i,
  output logic              rk_yumi_o,
  input  logic [3:0]        rd_idx_i,
  output logic [0:RK_W-1]   rd_rk_o,
  output logic              keys_valid_o,
  output logic              busy_o
);

  localparam logic [1:0] ST_IDLE  = 2'(KS_IDLE);
  localparam logic [1:0] ST_ISSUE = 2'(KS_ISSUE);
  localparam logic [1:0] ST_WAIT  = 2'(KS_WAIT);
  localparam logic [1:0] ST_DONE  = 2'(KS_DONE);

  logic [1:0]         state;
  logic [2:0]         round;
  logic               key_accept;
  logic               rsp_take;
  logic               last_round;
  logic               wr_en;
  logic [2:0]         wr_pair;
  logic [0:KEY_W-1]   wr_data;
  logic [0:RK_W-1]    rd_raw;

  assign key_ready_o  = (state == ST_IDLE) || (state == ST_DONE);
  assign keys_valid_o = (state == ST_DONE);
  assign busy_o       = (state == ST_ISSUE) || (state == ST_WAIT);
  assign rk_v_o       = (state == ST_ISSUE);
  // Every response is consumed the cycle it appears; outside WAIT it is simply
  // dropped, which drains anything left in flight across a reset.
  assign rk_yumi_o    = rk_v_i;

  assign key_accept = key_v_i && key_ready_o;
  assign rsp_take   = (state == ST_WAIT) && rk_v_i;
  assign last_round = (round == 3'(AES256_LAST_ROUND));

`ifdef KEY_SCHED_ZEROIZE_EN
  logic load_pending;
  logic clr;

  assign clr = !reset_n_i || key_accept;
`endif

  // Buffer write selection. A round response writes pair r; the key itself
  // fills pair 0, either on the accept edge or, when the accept edge is spent
  // zeroizing, one cycle later from the latched copy in rk_k_o. Writes are
  // suppressed during reset so a late response can never land.
  always_comb begin
    wr_en   = 1'b0;
    wr_pair = 3'd0;
    wr_data = rk_result_i;
    if (reset_n_i) begin
      if (rsp_take) begin
        wr_en   = 1'b1;
        wr_pair = round;
        wr_data = rk_result_i;
      end
`ifdef KEY_SCHED_ZEROIZE_EN
      else if (load_pending) begin
        wr_en   = 1'b1;
        wr_pair = 3'd0;
        wr_data = rk_k_o;
      end
`else
      else if (key_accept) begin
        wr_en   = 1'b1;
        wr_pair = 3'd0;
        wr_data = key_i;
      end
`endif
    end
  end

  // Sequencer: one ISSUE/WAIT pair per round. rk_k_o/rk_r_o only change on a
  // key accept or a consumed response, so they stay stable while rk_v_o waits
  // for rk_ready_i.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state  <= ST_IDLE;
      round  <= 3'd1;
      rk_k_o <= '0;
      rk_r_o <= '0;
`ifdef KEY_SCHED_ZEROIZE_EN
      load_pending <= 1'b0;
`endif
    end else begin
`ifdef KEY_SCHED_ZEROIZE_EN
      load_pending <= key_accept;
`endif
      case (state)
        ST_IDLE, ST_DONE: begin
          if (key_v_i) begin
            rk_k_o <= key_i;
            rk_r_o <= 4'd1;
            round  <= 3'd1;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (rk_ready_i) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (rk_v_i) begin
            if (last_round) begin
              state <= ST_DONE;
            end else begin
              rk_k_o <= rk_result_i;
              rk_r_o <= {1'b0, round + 3'd1};
              round  <= round + 3'd1;
              state  <= ST_ISSUE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rk_buffer #(
    .NUM_RK (NUM_RK),
    .RK_W   (RK_W)
  ) u_rk_buffer (
    .clk     (clk_i),
`ifdef KEY_SCHED_ZEROIZE_EN
    .clr     (clr),
`endif
    .wr_en   (wr_en),
    .wr_pair (wr_pair),
    .wr_data (wr_data),
    .rd_idx  (rd_idx_i),
    .rd_data (rd_raw)
  );

`ifdef KEY_SCHED_ZEROIZE_EN
  assign rd_rk_o = keys_valid_o ? rd_raw : '0;
`else
  assign rd_rk_o = rd_raw;
`endif

endmodule

// File: tb/tb_key_sched_ctrl.sv
// ----------------------------------------------------------------------------
// tb_key_sched_ctrl
//   Self-checking bench for key_sched_ctrl. A behavioural round_key responder
//   (random ready / latency) answers requests; expected round keys come from a
//   full AES-256 key expansion computed in the bench.
// ----------------------------------------------------------------------------
module tb_key_sched_ctrl;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic [0:255]  key_i;
  logic          key_v_i;
  logic          key_ready_o;
  logic [0:255]  rk_k_o;
  logic [3:0]    rk_r_o;
  logic          rk_v_o;
  logic          rk_ready_i;
  logic [0:255]  rk_result_i;
  logic          rk_v_i;
  logic          rk_yumi_o;
  logic [3:0]    rd_idx_i;
  logic [0:127]  rd_rk_o;
  logic          keys_valid_o;
  logic          busy_o;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]    sbox_tab [256];
  logic [31:0]   w_exp [60];
  logic [0:127]  exp_buf [15];
  int            r_log [$];

  bit            force_stall = 1'b0;
  bit            manual      = 1'b0;
  bit            inject_v    = 1'b0;
  logic [0:255]  inject_data = '0;
  int            hold_round  = 0;

  bit            resp_pending;
  int            resp_lat;
  int            resp_r;
  logic [0:255]  resp_res;

  key_sched_ctrl dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .key_i        (key_i),
    .key_v_i      (key_v_i),
    .key_ready_o  (key_ready_o),
    .rk_k_o       (rk_k_o),
    .rk_r_o       (rk_r_o),
    .rk_v_o       (rk_v_o),
    .rk_ready_i   (rk_ready_i),
    .rk_result_i  (rk_result_i),
    .rk_v_i       (rk_v_i),
    .rk_yumi_o    (rk_yumi_o),
    .rd_idx_i     (rd_idx_i),
    .rd_rk_o      (rd_rk_o),
    .keys_valid_o (keys_valid_o),
    .busy_o       (busy_o)
  );

  always #50 clk_i = ~clk_i;

  // GF(2^8) multiply with the AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // AES-256 schedule rule for word i from w[i-1] and w[i-8].
  function automatic logic [31:0] next_word(input logic [31:0] w_prev, input logic [31:0] w_back8,
                                            input int i);
    logic [31:0] t;
    logic [7:0]  rcon;
    t = w_prev;
    rcon = 8'h01 << ((i / 8) - 1);
    if (i % 8 == 0)      t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
    else if (i % 8 == 4) t = sub_word(t);
    return w_back8 ^ t;
  endfunction

  task automatic expand_key(input logic [0:255] key);
    for (int i = 0; i < 8; i++) w_exp[i] = key[32*i +: 32];
    for (int i = 8; i < 60; i++) w_exp[i] = next_word(w_exp[i-1], w_exp[i-8], i);
  endtask

  function automatic logic [0:127] rk_of(input int j);
    return {w_exp[4*j], w_exp[4*j+1], w_exp[4*j+2], w_exp[4*j+3]};
  endfunction

  // round_key stub: words 8r..8r+7 from words 8(r-1)..8r-1.
  function automatic logic [0:255] rk_step(input logic [0:255] k, input logic [3:0] r);
    logic [31:0] w [16];
    for (int j = 0; j < 8; j++) w[j] = k[32*j +: 32];
    for (int j = 8; j < 16; j++) w[j] = next_word(w[j-1], w[j-8], 8*int'(r) + j - 8);
    return {w[8], w[9], w[10], w[11], w[12], w[13], w[14], w[15]};
  endfunction

  function automatic logic [0:255] rand_key();
    logic [0:255] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a key at a negedge and return at the negedge after the accept edge.
  task automatic applyStimulus(input logic [0:255] key);
    for (int n = 0; n < 400 && key_ready_o !== 1'b1; n++) @(negedge clk_i);
    checkOutput("key_ready_before_accept", 256'(key_ready_o), 256'(1));
    key_i   = key;
    key_v_i = 1'b1;
    @(negedge clk_i);
    key_v_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int n = 0; n < 400 && keys_valid_o !== 1'b1; n++) @(negedge clk_i);
    checkOutput(tag, 256'(keys_valid_o), 256'(1));
  endtask

  task automatic commit_full();
    for (int j = 0; j < 15; j++) exp_buf[j] = rk_of(j);
  endtask

  task automatic check_buffer(input string tag);
    for (int i = 0; i < 15; i++) begin
      rd_idx_i = 4'(i);
      #1;
      checkOutput($sformatf("%s_rk%0d", tag, i), 256'(rd_rk_o), 256'(exp_buf[i]));
    end
    rd_idx_i = 4'd0;
  endtask

  task automatic check_rounds(input string tag, input int base);
    checkOutput($sformatf("%s_round_count", tag), 256'(r_log.size() - base), 256'(7));
    for (int i = 0; i < 7; i++) begin
      if (base + i < r_log.size())
        checkOutput($sformatf("%s_round%0d", tag, i), 256'(r_log[base+i]), 256'(i + 1));
    end
  endtask

  task automatic check_reset_state(input string tag);
    checkOutput({tag, "_key_ready"},  256'(key_ready_o),  256'(1));
    checkOutput({tag, "_keys_valid"}, 256'(keys_valid_o), 256'(0));
    checkOutput({tag, "_busy"},       256'(busy_o),       256'(0));
    checkOutput({tag, "_rk_v"},       256'(rk_v_o),       256'(0));
    checkOutput({tag, "_rk_r"},       256'(rk_r_o),       256'(0));
    checkOutput({tag, "_rk_k"},       256'(rk_k_o),       256'(0));
  endtask

  // Behavioural round_key: acts 1 time unit after each negedge so the main
  // process has already updated reset / control for the coming edge.
  initial begin
    rk_ready_i   = 1'b0;
    rk_v_i       = 1'b0;
    rk_result_i  = '0;
    resp_pending = 1'b0;
    resp_lat     = 0;
    resp_r       = 0;
    resp_res     = '0;
    forever begin
      @(negedge clk_i);
      #1;
      if (!reset_n_i) begin
        resp_pending = 1'b0;
        rk_v_i       = 1'b0;
        rk_ready_i   = 1'b0;
      end else if (manual) begin
        resp_pending = 1'b0;
        rk_ready_i   = 1'b0;
        rk_v_i       = inject_v;
        rk_result_i  = inject_data;
      end else if (resp_pending) begin
        rk_ready_i = 1'b0;
        if (rk_v_i) begin
          resp_pending = 1'b0;
          rk_v_i       = 1'b0;
        end else if (resp_lat > 0) begin
          resp_lat--;
        end else if (resp_r != hold_round) begin
          rk_v_i      = 1'b1;
          rk_result_i = resp_res;
        end
      end else begin
        rk_v_i     = 1'b0;
        rk_ready_i = force_stall ? 1'b0 : ($urandom_range(0, 2) != 0);
        if (rk_ready_i && rk_v_o) begin
          resp_pending = 1'b1;
          resp_res     = rk_step(rk_k_o, rk_r_o);
          resp_r       = int'(rk_r_o);
          resp_lat     = $urandom_range(0, 3);
          r_log.push_back(int'(rk_r_o));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    logic [0:255] key1, key2, key3, key4, key5a, key5b, key_bad;
    logic [0:127] old_rk9, exp_rk0, exp_rk9_after;
    int           base;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int c = 1; c < 256; c++) if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
      sbox_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                    {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

    reset_n_i = 1'b0;
    key_v_i   = 1'b0;
    key_i     = '0;
    rd_idx_i  = 4'd0;
    @(negedge clk_i);
    @(negedge clk_i);
    check_reset_state("reset");
    reset_n_i = 1'b1;
    @(negedge clk_i);

    // Known-answer key, random handshake timing.
    key1 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    expand_key(key1);
    base = r_log.size();
    applyStimulus(key1);
`ifdef KEY_SCHED_ZEROIZE_EN
    exp_rk0 = '0;
`else
    exp_rk0 = key1[0:127];
`endif
    rd_idx_i = 4'd0;
    #1;
    checkOutput("t1_rk0_after_accept", 256'(rd_rk_o), 256'(exp_rk0));
    wait_done("t1_keys_valid");
    commit_full();
    check_buffer("t1");
    rd_idx_i = 4'd2;
    #1;
    checkOutput("t1_rk2_kat", 256'(rd_rk_o), 256'(128'h9ba354118e6925afa51a8b5f2067fcde));
    rd_idx_i = 4'd14;
    #1;
    checkOutput("t1_rk14_kat", 256'(rd_rk_o), 256'(128'hfe4890d1e6188d0b046df344706c631e));
    rd_idx_i = 4'd0;
    check_rounds("t1", base);

    // Request held while round_key is not ready.
    key2 = rand_key();
    expand_key(key2);
    force_stall = 1'b1;
    base = r_log.size();
    applyStimulus(key2);
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("t2_stall%0d_rk_v", c), 256'(rk_v_o), 256'(1));
      checkOutput($sformatf("t2_stall%0d_rk_k", c), 256'(rk_k_o), 256'(key2));
      checkOutput($sformatf("t2_stall%0d_rk_r", c), 256'(rk_r_o), 256'(1));
      @(negedge clk_i);
    end
    force_stall = 1'b0;
    wait_done("t2_keys_valid");
    commit_full();
    check_buffer("t2");
    check_rounds("t2", base);

    // Second key offered mid-expansion is ignored.
    key3 = {32{8'h64}};
    expand_key(key3);
    base = r_log.size();
    applyStimulus(key3);
    for (int n = 0; n < 100 && !(busy_o === 1'b1 && rk_v_o === 1'b0); n++) @(negedge clk_i);
    checkOutput("t3_wait_reached", 256'(busy_o && !rk_v_o), 256'(1));
    key_bad = rand_key();
    key_i   = key_bad;
    key_v_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("t3_key_ready_low%0d", c), 256'(key_ready_o), 256'(0));
      @(negedge clk_i);
    end
    key_v_i = 1'b0;
    wait_done("t3_keys_valid");
    commit_full();
    check_buffer("t3");
    check_rounds("t3", base);

    // Reset while waiting on round 4, then a late response.
    key4 = rand_key();
    expand_key(key4);
    hold_round = 4;
    applyStimulus(key4);
    for (int n = 0; n < 200 && !(busy_o === 1'b1 && rk_v_o === 1'b0 && rk_r_o === 4'd4); n++)
      @(negedge clk_i);
    checkOutput("t4_wait_r4_reached", 256'(busy_o && !rk_v_o && rk_r_o == 4'd4), 256'(1));
    reset_n_i = 1'b0;
    manual    = 1'b1;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    check_reset_state("t4_reset");
    for (int j = 0; j < 8; j++) exp_buf[j] = rk_of(j);
`ifdef KEY_SCHED_ZEROIZE_EN
    for (int j = 0; j < 15; j++) exp_buf[j] = '0;
`endif
    inject_data = rand_key();
    inject_v    = 1'b1;
    @(negedge clk_i);
    checkOutput("t4_late_yumi", 256'(rk_yumi_o), 256'(1));
    inject_v = 1'b0;
    @(negedge clk_i);
    checkOutput("t4_idle_key_ready",  256'(key_ready_o),  256'(1));
    checkOutput("t4_idle_keys_valid", 256'(keys_valid_o), 256'(0));
    checkOutput("t4_idle_busy",       256'(busy_o),       256'(0));
    check_buffer("t4");
    manual     = 1'b0;
    hold_round = 0;
    @(negedge clk_i);

    // New key accepted from DONE; stale entry visible right after accept.
    key5a = rand_key();
    expand_key(key5a);
    applyStimulus(key5a);
    wait_done("t5_first_keys_valid");
    commit_full();
    old_rk9 = exp_buf[9];
    key5b = rand_key();
    expand_key(key5b);
    base = r_log.size();
    applyStimulus(key5b);
    checkOutput("t5_keys_valid_drop", 256'(keys_valid_o), 256'(0));
`ifdef KEY_SCHED_ZEROIZE_EN
    exp_rk9_after = '0;
`else
    exp_rk9_after = old_rk9;
`endif
    rd_idx_i = 4'd9;
    #1;
    checkOutput("t6_rk9_after_accept", 256'(rd_rk_o), 256'(exp_rk9_after));
    rd_idx_i = 4'd0;
    wait_done("t5_keys_valid");
    commit_full();
    check_buffer("t5");
    check_rounds("t5", base);
    rd_idx_i = 4'd15;
    #1;
    checkOutput("t5_idx15_zero", 256'(rd_rk_o), 256'(0));
    rd_idx_i = 4'd0;

    @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/key_sched_ctrl.md
Name: key_sched_ctrl

Overview:
Sequencer for AES-256 key expansion.
- Accepts a 256-bit cipher key from the host and drives the round_key stage through rounds r=1..7 over its valid/ready handshake.
- Consumes each 256-bit round_key result and splits it into 128-bit round keys.
- Stores all 15 round keys (RK0..RK14) in a local buffer, which the cipher datapath reads by index.

Parameters:
NUM_RK, 15, number of 128-bit round keys stored (AES-256).
KEY_W, 256, cipher key / round_key data width.
RK_W, 128, round key width.

Ports:
clk_i  in  1  clock; all logic on posedge.
reset_n_i  in  1  synchronous, active-low reset.
key_i  in  256  cipher key, bit 0 = MSB (big-endian [0:255]).
key_v_i  in  1  key valid from host.
key_ready_o  out  1  ready for new key; transfer on key_v_i & key_ready_o.
rk_k_o  out  256  key word to round_key (its k input).
rk_r_o  out  4  round index to round_key (its r input).
rk_v_o  out  1  request valid to round_key.
rk_ready_i  in  1  round_key ready_o.
rk_result_i  in  256  round_key result.
rk_v_i  in  1  round_key v_o.
rk_yumi_o  out  1  consume strobe to round_key yumi_i.
rd_idx_i  in  4  round-key read index.
rd_rk_o  out  128  round key at rd_idx_i (combinational read).
keys_valid_o  out  1  all 15 round keys valid for the current key.
busy_o  out  1  expansion in progress.

Behaviour:
- Reset (reset_n_i=0 at posedge):
  - State IDLE; round counter = 1.
  - key_ready_o=1, keys_valid_o=0, busy_o=0, rk_v_o=0, rk_r_o=0, rk_k_o=0.
  - Buffer contents untouched, except when the optional feature is enabled.
  - round_key shares reset_n_i.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: key_ready_o=1.
  - On key accept: RK0=key_i[0:127], RK1=key_i[128:255]; rk_k_o<=key_i; rk_r_o<=1; keys_valid_o<=0; go to ISSUE.
- ISSUE: rk_v_o=1; rk_k_o and rk_r_o held stable.
  - On rk_v_o & rk_ready_i: go to WAIT next cycle, with rk_v_o=0.
- WAIT: rk_yumi_o = rk_v_i (same-cycle consume).
  - On rk_v_i with round r:
    - RK[2r] = rk_result_i[0:127].
    - RK[2r+1] = rk_result_i[128:255], written only if 2r+1 < 15. For r=7 the second half is discarded.
  - If r<7: rk_k_o<=rk_result_i, rk_r_o<=r+1, go to ISSUE.
  - If r=7: go to DONE.
- DONE: keys_valid_o=1; key_ready_o=1.
  - A new key accept behaves exactly as in IDLE: keys_valid_o drops the next cycle.
- busy_o=1 in ISSUE and WAIT. key_ready_o=0 in ISSUE and WAIT, so key_v_i is ignored there and no key is queued.
- Latency: RK0/RK1 are written 1 cycle after key accept. Total expansion time = 7 × (issue wait + round_key latency + 1).
- Stale responses: a rk_v_i seen in IDLE/DONE/ISSUE is acknowledged (rk_yumi_o=1) and discarded, with no buffer write. This drains any result left in flight after a reset.
- Read port:
  - rd_rk_o = RK[rd_idx_i] for idx 0..14.
  - rd_idx_i=15 returns 0.
  - A read and a write of the same index in the same cycle returns the old value.
- Reset mid-expansion: returns to IDLE with keys_valid_o=0. The partial buffer is never flagged valid.

Optional Feature:
KEY_SCHED_ZEROIZE_EN:
- Defined: on reset and on every key accept, all 15 buffer entries clear to 0 in that cycle; RK0/RK1 load 1 cycle later. In addition, rd_rk_o returns 0 whenever keys_valid_o=0.
- Undefined: no clearing; rd_rk_o always returns the raw buffer contents, including stale values.

Decomposition:
- Shared package aes_pkg:
  - typedefs key256_t (logic [0:255]) and rk128_t (logic [0:127]).
  - constants AES256_NUM_RK=15 and AES256_LAST_ROUND=7.
  - FSM enum ks_state_e.
- One sub-module, rk_buffer: 15×128 register file with one write port and one async read port, plus the zeroize clear under the macro.

Test Plan:
1. Key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 with a behavioural round_key model -> RK2 = 9ba354118e6925afa51a8b5f2067fcde, RK14 = fe4890d1e6188d0b046df344706c631e, keys_valid_o=1, rk_r_o sequence 1..7.
2. Hold rk_ready_i=0 for 5 cycles during ISSUE -> rk_v_o held high, rk_k_o/rk_r_o stable, exactly one transfer per round.
3. Key 64646464…64 accepted; assert key_v_i with a second key during WAIT -> second key ignored (key_ready_o=0), buffer reflects the first key only.
4. Pulse reset_n_i=0 while in WAIT at r=4, then inject a late rk_v_i -> yumi returned, no buffer write, keys_valid_o=0, state IDLE.
5. In DONE, accept a new key -> keys_valid_o=0 the next cycle, then 1 after 7 rounds. rd_idx_i=15 -> rd_rk_o=0.
6. With KEY_SCHED_ZEROIZE_EN, read RK9 immediately after a new key accept -> 0; without the macro -> old RK9 value.
